// File: rtl/global_defs.sv
// rtl/global_defs.sv - shared MPU matrix dimension constants
package global_defs;
    localparam int M               = 4;
    localparam int N               = 4;
    localparam int MBITS           = 2;
    localparam int NBITS           = 2;
    localparam int MATRIX_REG_BITS = 2;
endpackage

// File: rtl/mpu_store_if.sv
// rtl/mpu_store_if.sv - memory sink and register file ports of the matrix store path
interface mpu_store_if;
    import global_defs::*;

    logic                     store_req_in;
    logic [MATRIX_REG_BITS:0] mem_store_addr_in;
    logic [31:0]              mem_store_element_out;
    logic                     mem_store_valid_out;
    logic                     mem_store_ready_in;
    logic [MBITS:0]           mem_store_i_loc_out;
    logic [NBITS:0]           mem_store_j_loc_out;
    logic [MBITS:0]           mem_store_m_size_out;
    logic [NBITS:0]           mem_store_n_size_out;
    logic                     mem_store_last_out;
    logic                     mem_store_done_out;
    logic                     mem_store_error_out;
    logic                     reg_store_req_out;
    logic                     store_ready_in;
    logic                     reg_store_rd_out;
    logic [MATRIX_REG_BITS:0] reg_store_addr_out;
    logic [MBITS:0]           reg_store_i_loc_out;
    logic [NBITS:0]           reg_store_j_loc_out;
    logic [31:0]              reg_store_element_in;
    logic [MBITS:0]           reg_m_store_size_in;
    logic [NBITS:0]           reg_n_store_size_in;

    // Store engine side
    modport master (
        input  store_req_in, mem_store_addr_in, mem_store_ready_in, store_ready_in,
               reg_store_element_in, reg_m_store_size_in, reg_n_store_size_in,
        output mem_store_element_out, mem_store_valid_out, mem_store_i_loc_out,
               mem_store_j_loc_out, mem_store_m_size_out, mem_store_n_size_out,
               mem_store_last_out, mem_store_done_out, mem_store_error_out,
               reg_store_req_out, reg_store_rd_out, reg_store_addr_out,
               reg_store_i_loc_out, reg_store_j_loc_out
    );

    // Memory sink / register file side
    modport slave (
        output store_req_in, mem_store_addr_in, mem_store_ready_in, store_ready_in,
               reg_store_element_in, reg_m_store_size_in, reg_n_store_size_in,
        input  mem_store_element_out, mem_store_valid_out, mem_store_i_loc_out,
               mem_store_j_loc_out, mem_store_m_size_out, mem_store_n_size_out,
               mem_store_last_out, mem_store_done_out, mem_store_error_out,
               reg_store_req_out, reg_store_rd_out, reg_store_addr_out,
               reg_store_i_loc_out, reg_store_j_loc_out
    );
endinterface

// File: rtl/mpu_store.sv
// rtl/mpu_store.sv - streams one register file matrix to memory in row-major order
module mpu_store
    import global_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    mpu_store_if.master bus
);

    localparam logic [1:0] STORE_IDLE    = 2'd0;
    localparam logic [1:0] STORE_REQUEST = 2'd1;
    localparam logic [1:0] STORE_READ    = 2'd2;
    localparam logic [1:0] STORE_SEND    = 2'd3;

    logic [1:0]               state;
    logic [MATRIX_REG_BITS:0] addr_q;
    logic [MBITS:0]           m_q, row_ptr, i_q;
    logic [NBITS:0]           n_q, col_ptr, j_q;
    logic [31:0]              elem_q;
    logic                     done_q, err_q;
    logic                     size_err, ptr_last;

    // Reject empty or oversized stored matrices before reserving the register file
    always_comb begin
        size_err = (bus.reg_m_store_size_in == '0) ||
                   (bus.reg_n_store_size_in == '0) ||
                   (bus.reg_m_store_size_in > (MBITS+1)'(M)) ||
                   (bus.reg_n_store_size_in > (NBITS+1)'(N));
    end

    assign ptr_last = (row_ptr == m_q - (MBITS+1)'(1)) && (col_ptr == n_q - (NBITS+1)'(1));

    // Transfer sequencer: reserve, read one element, hand it to memory, repeat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= STORE_IDLE;
            addr_q  <= '0;
            m_q     <= '0;
            n_q     <= '0;
            row_ptr <= '0;
            col_ptr <= '0;
            i_q     <= '0;
            j_q     <= '0;
            elem_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                STORE_IDLE: begin
                    if (bus.store_req_in) begin
                        if (size_err) begin
                            err_q <= 1'b1;
                        end else begin
                            addr_q  <= bus.mem_store_addr_in;
                            m_q     <= bus.reg_m_store_size_in;
                            n_q     <= bus.reg_n_store_size_in;
                            row_ptr <= '0;
                            col_ptr <= '0;
                            state   <= STORE_REQUEST;
                        end
                    end
                end
                STORE_REQUEST: begin
                    if (bus.store_ready_in) begin
                        state <= STORE_READ;
                    end
                end
                STORE_READ: begin
                    elem_q <= bus.reg_store_element_in;
                    i_q    <= row_ptr;
                    j_q    <= col_ptr;
                    state  <= STORE_SEND;
                end
                STORE_SEND: begin
                    if (bus.mem_store_ready_in) begin
                        if (ptr_last) begin
                            done_q <= 1'b1;
                            state  <= STORE_IDLE;
                        end else begin
                            if (col_ptr == n_q - (NBITS+1)'(1)) begin
                                col_ptr <= '0;
                                row_ptr <= row_ptr + (MBITS+1)'(1);
                            end else begin
                                col_ptr <= col_ptr + (NBITS+1)'(1);
                            end
                            state <= STORE_READ;
                        end
                    end
                end
                default: state <= STORE_IDLE;
            endcase
        end
    end

    // In IDLE the address passes straight through so the size inputs describe the candidate
    assign bus.reg_store_addr_out    = (state == STORE_IDLE) ? bus.mem_store_addr_in : addr_q;
    assign bus.reg_store_req_out     = (state != STORE_IDLE);
    assign bus.reg_store_rd_out      = (state == STORE_READ);
    assign bus.reg_store_i_loc_out   = row_ptr;
    assign bus.reg_store_j_loc_out   = col_ptr;
    assign bus.mem_store_valid_out   = (state == STORE_SEND);
    assign bus.mem_store_element_out = elem_q;
    assign bus.mem_store_i_loc_out   = i_q;
    assign bus.mem_store_j_loc_out   = j_q;
    assign bus.mem_store_m_size_out  = m_q;
    assign bus.mem_store_n_size_out  = n_q;
    assign bus.mem_store_last_out    = (state == STORE_SEND) &&
                                       (i_q == m_q - (MBITS+1)'(1)) &&
                                       (j_q == n_q - (NBITS+1)'(1));
    assign bus.mem_store_done_out    = done_q;
    assign bus.mem_store_error_out   = err_q;

endmodule

// File: tb/tb_mpu_store.sv
// tb/tb_mpu_store.sv - self-checking bench for mpu_store
module tb_mpu_store;
    import global_defs::*;

    logic clk;
    logic rst;
    mpu_store_if bus();

    mpu_store dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] e;
        int          i;
        int          j;
        logic        last;
        int          m;
        int          n;
    } exp_t;

    typedef struct {
        int addr;
        int delay;
        int mode;
        bit err;
    } vec_t;

    exp_t q[$];
    vec_t vecs[8];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic int sz_m(int a);
        case (a)
            0: return 0; 1: return 2; 2: return 3; 3: return 2;
            4: return 1; 5: return 2; 6: return 5; default: return 4;
        endcase
    endfunction

    function automatic int sz_n(int a);
        case (a)
            0: return 2; 1: return 3; 2: return 3; 3: return 2;
            4: return 1; 5: return 5; 6: return 1; default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] i2f(int k);
        int e;
        e = 0;
        while ((k >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((k - (1 << e)) << (23 - e))};
    endfunction

    function automatic logic [31:0] elem(int a, int i, int j);
        return i2f(i * sz_n(a) + j + 1 + 16 * ((a + 7) & 7));
    endfunction

    // Register file model: sizes and data follow the driven address combinationally
    always_comb begin
        bus.reg_m_store_size_in  = 3'(sz_m(int'(bus.reg_store_addr_out)));
        bus.reg_n_store_size_in  = 3'(sz_n(int'(bus.reg_store_addr_out)));
        bus.reg_store_element_in = elem(int'(bus.reg_store_addr_out),
                                        int'(bus.reg_store_i_loc_out),
                                        int'(bus.reg_store_j_loc_out));
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a request in the current (IDLE) cycle and follows it to done or error.
    // Returns in the done cycle so a caller can re-request there.
    task automatic run_store(int a, int d, int mode, bit err);
        int c, m, n, hs, vk, exp_done, first_valid;
        bit stalled;
        logic [31:0] pe;
        logic [2:0]  pi, pj;
        exp_t x;
        m = sz_m(a);
        n = sz_n(a);
        bus.mem_store_addr_in  = 3'(a);
        bus.store_req_in       = 1'b1;
        bus.store_ready_in     = 1'b0;
        bus.mem_store_ready_in = 1'b0;
        if (!err) begin
            for (int i = 0; i < m; i++)
                for (int j = 0; j < n; j++)
                    q.push_back('{elem(a, i, j), i, j, (i == m - 1) && (j == n - 1), m, n});
        end
        step();
        bus.store_req_in = 1'b0;
        if (err) begin
            check("err_pulse", bus.mem_store_error_out, 1);
            check("err_no_req", bus.reg_store_req_out, 0);
            step();
            check("err_clear", bus.mem_store_error_out, 0);
            check("err_idle", bus.reg_store_req_out, 0);
            return;
        end
        check("no_err", bus.mem_store_error_out, 0);
        exp_done    = 2 + d + m * n * (mode == 0 ? 2 : 4);
        first_valid = -1;
        hs = 0; vk = 0; stalled = 0; pe = '0; pi = '0; pj = '0;
        for (c = 1; c < 400; c++) begin
            if (bus.mem_store_done_out) begin
                check("done_cycle", c, exp_done);
                check("handshakes", hs, m * n);
                check("sb_empty", q.size(), 0);
                check("req_drop", bus.reg_store_req_out, 0);
                check("first_valid", first_valid, 3 + d);
                check("m_size_hold", bus.mem_store_m_size_out, m);
                bus.mem_store_ready_in = 1'b0;
                bus.store_ready_in     = 1'b0;
                return;
            end
            check("req_held", bus.reg_store_req_out, 1);
            if (c < 2 + d) begin
                check("no_rd_early", bus.reg_store_rd_out, 0);
                check("no_valid_early", bus.mem_store_valid_out, 0);
            end
            if (c == 2 + d) check("first_rd", bus.reg_store_rd_out, 1);
            if (bus.mem_store_valid_out) begin
                if (first_valid < 0) first_valid = c;
                check("rd_in_send", bus.reg_store_rd_out, 0);
                if (stalled) begin
                    check("stall_elem", bus.mem_store_element_out, pe);
                    check("stall_i", bus.mem_store_i_loc_out, pi);
                    check("stall_j", bus.mem_store_j_loc_out, pj);
                end
                pe = bus.mem_store_element_out;
                pi = bus.mem_store_i_loc_out;
                pj = bus.mem_store_j_loc_out;
                bus.mem_store_ready_in = (mode == 0) || (vk >= 2);
                vk++;
                stalled = !bus.mem_store_ready_in;
                if (bus.mem_store_ready_in) begin
                    vk = 0;
                    hs++;
                    if (q.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        x = q.pop_front();
                        check("elem", bus.mem_store_element_out, x.e);
                        check("i_loc", bus.mem_store_i_loc_out, x.i);
                        check("j_loc", bus.mem_store_j_loc_out, x.j);
                        check("last", bus.mem_store_last_out, x.last);
                        check("n_size", bus.mem_store_n_size_out, x.n);
                    end
                end
            end else begin
                bus.mem_store_ready_in = 1'b0;
            end
            bus.store_ready_in = (c >= 1 + d);
            step();
        end
        check("timeout", c, exp_done);
    endtask

    initial begin
        int vc;
        vecs[0] = '{1, 0, 0, 1'b0};
        vecs[1] = '{0, 0, 0, 1'b1};
        vecs[2] = '{5, 0, 0, 1'b1};
        vecs[3] = '{6, 0, 0, 1'b1};
        vecs[4] = '{1, 5, 0, 1'b0};
        vecs[5] = '{2, 0, 1, 1'b0};
        vecs[6] = '{4, 0, 0, 1'b0};
        vecs[7] = '{7, 2, 1, 1'b0};

        rst = 1'b1;
        bus.store_req_in       = 1'b0;
        bus.mem_store_addr_in  = 3'd2;
        bus.mem_store_ready_in = 1'b0;
        bus.store_ready_in     = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_valid", bus.mem_store_valid_out, 0);
        check("rst_req", bus.reg_store_req_out, 0);
        check("rst_done", bus.mem_store_done_out, 0);
        check("rst_err", bus.mem_store_error_out, 0);
        check("rst_m", bus.mem_store_m_size_out, 0);
        check("rst_elem", bus.mem_store_element_out, 0);
        check("rst_addr_follow", bus.reg_store_addr_out, 2);
        step();

        for (int v = 0; v < 8; v++) begin
            run_store(vecs[v].addr, vecs[v].delay, vecs[v].mode, vecs[v].err);
            step();
        end

        // Reset on the second SEND of a 2x2 store
        bus.mem_store_addr_in = 3'd3;
        bus.store_req_in      = 1'b1;
        step();
        bus.store_req_in       = 1'b0;
        bus.store_ready_in     = 1'b1;
        bus.mem_store_ready_in = 1'b1;
        vc = 0;
        for (int k = 0; k < 20 && vc < 2; k++) begin
            if (bus.mem_store_valid_out) vc++;
            if (vc < 2) step();
        end
        check("reached_send2", vc, 2);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", bus.mem_store_valid_out, 0);
        check("arst_req", bus.reg_store_req_out, 0);
        check("arst_last", bus.mem_store_last_out, 0);
        check("arst_i", bus.mem_store_i_loc_out, 0);
        check("arst_n", bus.mem_store_n_size_out, 0);
        check("arst_elem", bus.mem_store_element_out, 0);
        bus.store_ready_in     = 1'b0;
        bus.mem_store_ready_in = 1'b0;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("no_done_after_rst", bus.mem_store_done_out, 0);
            step();
        end
        q.delete();
        run_store(3, 0, 0, 1'b0);
        step();

        // Back-to-back: second request lands in the done cycle of a 1x1 store
        run_store(4, 0, 0, 1'b0);
        check("b2b_done_seen", bus.mem_store_done_out, 1);
        run_store(1, 0, 0, 1'b0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mpu_store.md
# mpu_store

Moves one matrix from the MPU register file to an external memory sink, one float at a time in row-major order. It is the register-file-to-memory counterpart of the matrix load path. The block reserves the register file through a request/ready handshake and reads element (i,j). It then presents each element to memory on a valid/ready handshake that tolerates backpressure. It reports the element coordinates, matrix size, last-element, done and error.

## Interface
Parameters (package constants from global_defs; the block has no local parameters):
- M, —, maximum rows
- N, —, maximum columns
- MBITS / NBITS, —, row and column index MSB
- MATRIX_REG_BITS, —, register address MSB

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high.
- store_req_in  in  1  start a store of the matrix at mem_store_addr_in.
- mem_store_addr_in  in  MATRIX_REG_BITS+1  source matrix register address.
- mem_store_element_out  out  32 (float_sp)  element to memory.
- mem_store_valid_out  out  1  element/location outputs valid.
- mem_store_ready_in  in  1  memory accepts element.
- mem_store_i_loc_out  out  MBITS+1  row of presented element.
- mem_store_j_loc_out  out  NBITS+1  column of presented element.
- mem_store_m_size_out  out  MBITS+1  latched row count.
- mem_store_n_size_out  out  NBITS+1  latched column count.
- mem_store_last_out  out  1  presented element is (m-1,n-1).
- mem_store_done_out  out  1  one-cycle pulse, transfer complete.
- mem_store_error_out  out  1  one-cycle pulse, request rejected.
- reg_store_req_out  out  1  register file reservation, held for whole transfer.
- store_ready_in  in  1  register file grants reservation.
- reg_store_rd_out  out  1  read strobe.
- reg_store_addr_out  out  MATRIX_REG_BITS+1  register address.
- reg_store_i_loc_out  out  MBITS+1  read row.
- reg_store_j_loc_out  out  NBITS+1  read column.
- reg_store_element_in  in  32  read data, combinational from the driven addr/i/j.
- reg_m_store_size_in  in  MBITS+1  stored row count of the addressed register, combinational.
- reg_n_store_size_in  in  NBITS+1  stored column count of the addressed register, combinational.

## Operation
- States: STORE_IDLE, STORE_REQUEST, STORE_READ, STORE_SEND.
- IDLE:
  - reg_store_addr_out follows mem_store_addr_in.
  - The size error condition is m==0, n==0, m>M or n>N, using the reg_*_size_in inputs.
  - If store_req_in is high and there is a size error: register mem_store_error_out=1 for the next cycle and stay in IDLE.
  - If store_req_in is high and there is no error: latch addr, m and n; clear row_ptr and col_ptr; go to REQUEST.
- REQUEST:
  - reg_store_req_out=1.
  - When store_ready_in is high, go to READ. Otherwise wait indefinitely.
- READ:
  - reg_store_req_out=1 and reg_store_rd_out=1; reg_store_i/j_loc_out equal row_ptr/col_ptr.
  - At the clock edge, capture reg_store_element_in and the pointers into the output registers, then go to SEND.
- SEND:
  - mem_store_valid_out=1. reg_store_req_out stays 1 and reg_store_rd_out=0.
  - Outputs hold stable while mem_store_ready_in is low.
  - On a cycle with ready high and the element not last: advance the pointers row-major (col+1; at col==n-1, col←0 and row+1) and return to READ.
  - On a cycle with ready high and the element last: pulse mem_store_done_out for the next cycle and return to IDLE.
- store_req_in is ignored outside IDLE.
- mem_store_last_out = valid & (i==m-1) & (j==n-1).
- Latched size and addr remain on the outputs after done, until the next accepted request.

## Timing
- Reset values:
  - State STORE_IDLE.
  - All 1-bit outputs 0.
  - Pointers, element, loc and size outputs 0.
  - reg_store_addr_out follows mem_store_addr_in.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs at their reset values. No done pulse. The register file reservation drops asynchronously.
- Accept at cycle 0 → REQUEST at cycle 1. With store_ready_in=1, READ at cycle 2 and first valid at cycle 3.
- Throughput is one element per 2 cycles with ready held high.
- A store of an m×n matrix with ready always high takes 2 + 2·m·n cycles from accept to done; done is high in the cycle after the final handshake.
- Error pulse appears in the cycle after the rejected request.
- store_req_in asserted in the same cycle as the done pulse (state IDLE) is accepted.
- Pointers never exceed m-1 or n-1; there is no wrap beyond the last element.

## Test plan
- 2×3 matrix at addr 1 holding 1.0..6.0, ready tied high → valid on cycles 3, 5, …, 13 in row-major order: (0,0)=1.0 … (1,2)=6.0 with last=1. Done at cycle 14. reg_store_req_out high on cycles 1–13.
- Request with stored size m=0, and separately with n=N+1 → error pulse 1 cycle later. State stays IDLE. reg_store_req_out never asserts.
- store_ready_in held low for 5 cycles → stays in REQUEST with no rd or valid. First valid follows 2 cycles after ready rises.
- mem_store_ready_in toggled 0,0,1 on each element of a 3×3 matrix → element and loc outputs stable while stalled. Exactly 9 handshakes. Done after (2,2).
- rst asserted on the 2nd SEND of a 2×2 store → all outputs 0 immediately and no done pulse. A new request after reset restarts at (0,0).
- 1×1 matrix → one valid with last=1, then done. A second store_req_in during the done cycle is accepted.
